snn_readout_scheduler: RTL and testbench

- Sequences the SNN output layer's classification readout.
- Accumulates per-class signed potential increments over a fixed number of timesteps.
- Then runs a serial argmax scan over the accumulators, one class per cycle.
- Returns the winning class and its value to the top-level FSM over a valid/ready handshake, with start/abort control.

---
 rtl/snn_readout_scheduler_if.sv | 38 +++
 rtl/snn_readout_scheduler.sv | 153 +++++++++++++++
 tb/tb_snn_readout_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_readout_scheduler_if.sv
// Readout scheduler bundle: control, step stream and result handshake.
// slave is the scheduler side, master is the controller side.
interface snn_readout_scheduler_if #(
    parameter int VEC_LEN   = 3,
    parameter int DATA_W    = 48,
    parameter int NUM_STEPS = 16
);
    localparam int CLS_W = $clog2(VEC_LEN);
    localparam int CNT_W = $clog2(NUM_STEPS + 1);

    logic                      i_clk_enable;
    logic                      i_start;
    logic                      i_abort;
    logic                      i_step_valid;
    logic [VEC_LEN*DATA_W-1:0] i_delta_flat;
    logic                      o_step_ready;
    logic                      o_busy;
    logic                      o_valid;
    logic                      i_ready;
    logic [CLS_W-1:0]          o_class;
    logic [DATA_W-1:0]         o_max_val;
    logic [CNT_W-1:0]          o_step_count;
    logic                      o_saturated;

    modport slave (
        input  i_clk_enable, i_start, i_abort, i_step_valid,
        input  i_delta_flat, i_ready,
        output o_step_ready, o_busy, o_valid, o_class,
        output o_max_val, o_step_count, o_saturated
    );

    modport master (
        output i_clk_enable, i_start, i_abort, i_step_valid,
        output i_delta_flat, i_ready,
        input  o_step_ready, o_busy, o_valid, o_class,
        input  o_max_val, o_step_count, o_saturated
    );
endinterface

// File: rtl/snn_readout_scheduler.sv
// SNN output-layer readout: saturating accumulation over a fixed number
// of timesteps, then a one-class-per-cycle argmax scan and result handshake.
module snn_readout_scheduler #(
    parameter int VEC_LEN   = 3,
    parameter int DATA_W    = 48,
    parameter int NUM_STEPS = 16
) (
    input logic clk,
    input logic rst,
    snn_readout_scheduler_if.slave bus
);
    localparam int CLS_W = $clog2(VEC_LEN);
    localparam int CNT_W = $clog2(NUM_STEPS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

    logic [1:0]               state;
    logic signed [DATA_W-1:0] acc     [VEC_LEN];
    logic signed [DATA_W-1:0] nxt_acc [VEC_LEN];
    logic signed [DATA_W:0]   sum     [VEC_LEN];
    logic                     clip;
    logic [CLS_W-1:0]         scan_idx;
    logic [CLS_W-1:0]         run_idx;
    logic [CLS_W-1:0]         cand_idx;
    logic signed [DATA_W-1:0] run_max;
    logic signed [DATA_W-1:0] cand_max;
    logic [CLS_W-1:0]         res_class;
    logic signed [DATA_W-1:0] res_max;
    logic [CNT_W-1:0]         step_count;
    logic                     valid;
    logic                     sat;
    logic                     step_fire;

    assign step_fire = bus.i_step_valid && (state == S_ACCUM);

    // Widen by one bit, add, then clamp to the signed DATA_W range.
    always_comb begin
        clip = 1'b0;
        for (int k = 0; k < VEC_LEN; k++) begin
            sum[k] = {acc[k][DATA_W-1], acc[k]}
                   + {bus.i_delta_flat[k*DATA_W+DATA_W-1],
                      bus.i_delta_flat[k*DATA_W +: DATA_W]};
            if (sum[k][DATA_W] != sum[k][DATA_W-1]) begin
                nxt_acc[k] = sum[k][DATA_W] ? MIN_V : MAX_V;
                clip = 1'b1;
            end else begin
                nxt_acc[k] = sum[k][DATA_W-1:0];
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        cand_idx = run_idx;
        cand_max = run_max;
        if (acc[scan_idx] > run_max) begin
            cand_idx = scan_idx;
            cand_max = acc[scan_idx];
        end
    end

    // Control FSM, accumulators and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            for (int k = 0; k < VEC_LEN; k++) acc[k] <= '0;
            scan_idx   <= '0;
            run_idx    <= '0;
            run_max    <= '0;
            res_class  <= '0;
            res_max    <= '0;
            step_count <= '0;
            valid      <= 1'b0;
            sat        <= 1'b0;
        end else if (bus.i_clk_enable) begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state      <= S_ACCUM;
                        for (int k = 0; k < VEC_LEN; k++) acc[k] <= '0;
                        step_count <= '0;
                        sat        <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (bus.i_abort) begin
                        state <= S_IDLE;
                    end else if (step_fire) begin
                        for (int k = 0; k < VEC_LEN; k++) acc[k] <= nxt_acc[k];
                        step_count <= step_count + 1'b1;
                        sat        <= sat | clip;
                        if (step_count == LAST_CNT) begin
                            state    <= S_SCAN;
                            scan_idx <= CLS_W'(1);
                            run_max  <= nxt_acc[0];
                            run_idx  <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (bus.i_abort) begin
                        state <= S_IDLE;
                    end else if (scan_idx == LAST_IDX) begin
                        res_class <= cand_idx;
                        res_max   <= cand_max;
                        valid     <= 1'b1;
                        state     <= S_OUTPUT;
                    end else begin
                        run_idx  <= cand_idx;
                        run_max  <= cand_max;
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (bus.i_abort) begin
                        state <= S_IDLE;
                        valid <= 1'b0;
                    end else if (bus.i_ready) begin
                        valid <= 1'b0;
                        if (bus.i_start) begin
                            state      <= S_ACCUM;
                            for (int k = 0; k < VEC_LEN; k++) acc[k] <= '0;
                            step_count <= '0;
                            sat        <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_step_ready = (state == S_ACCUM);
    assign bus.o_busy       = (state != S_IDLE);
    assign bus.o_valid      = valid;
    assign bus.o_class      = res_class;
    assign bus.o_max_val    = res_max;
    assign bus.o_step_count = step_count;
    assign bus.o_saturated  = sat;
endmodule

// File: tb/tb_snn_readout_scheduler.sv
// Bench for snn_readout_scheduler: vector table, corner sequences
// and randomized runs against an arithmetic argmax model.
module tb_snn_readout_scheduler;
    localparam int VL = 3;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int HI = (1 << (DW - 1)) - 1;
    localparam int LO = -(1 << (DW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    snn_readout_scheduler_if #(.VEC_LEN(VL), .DATA_W(DW), .NUM_STEPS(NS)) bus ();

    snn_readout_scheduler #(.VEC_LEN(VL), .DATA_W(DW), .NUM_STEPS(NS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d0;
        int d1;
        int d2;
        int cls;
        int mx;
        int sat;
    } vec_t;

    vec_t tbl [5];
    int   m_d [NS][VL];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint maxv;
        return longint'($signed(bus.o_max_val));
    endfunction

    task automatic set_delta(input int a, input int b, input int c);
        bus.i_delta_flat = {DW'(c), DW'(b), DW'(a)};
    endtask

    function automatic void model(output int cls, output int mx, output int sat);
        int a [VL];
        sat = 0;
        for (int k = 0; k < VL; k++) a[k] = 0;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < VL; k++) begin
                a[k] = a[k] + m_d[s][k];
                if (a[k] > HI) begin a[k] = HI; sat = 1; end
                if (a[k] < LO) begin a[k] = LO; sat = 1; end
            end
        end
        cls = 0;
        mx  = a[0];
        for (int k = 1; k < VL; k++) begin
            if (a[k] > mx) begin cls = k; mx = a[k]; end
        end
    endfunction

    task automatic fill_rows(input int a, input int b, input int c);
        for (int s = 0; s < NS; s++) begin
            m_d[s][0] = a;
            m_d[s][1] = b;
            m_d[s][2] = c;
        end
    endtask

    task automatic send_step(input int s);
        set_delta(m_d[s][0], m_d[s][1], m_d[s][2]);
        bus.i_step_valid = 1'b1;
        tick;
        bus.i_step_valid = 1'b0;
    endtask

    task automatic run_steps(input bit gaps);
        bus.i_start = 1'b1;
        tick;
        bus.i_start = 1'b0;
        check("start_step_ready", bus.o_step_ready, 1);
        for (int s = 0; s < NS; s++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick;
            send_step(s);
        end
    endtask

    task automatic finish_run(input string tag, input int cls, input int mx,
                              input int sat);
        int n;
        n = 0;
        while (!bus.o_valid && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, n, VL - 1);
        check({tag, "_class"}, bus.o_class, cls);
        check({tag, "_max"}, maxv(), mx);
        check({tag, "_sat"}, bus.o_saturated, sat);
        check({tag, "_count"}, bus.o_step_count, NS);
        bus.i_ready = 1'b1;
        tick;
        bus.i_ready = 1'b0;
        check({tag, "_valid_drop"}, bus.o_valid, 0);
        check({tag, "_idle"}, bus.o_busy, 0);
    endtask

    initial begin
        int cls, mx, sat;

        tbl[0] = '{1, 5, 2, 1, 20, 0};
        tbl[1] = '{3, 3, -1, 0, 12, 0};
        tbl[2] = '{-5, -2, -9, 1, -8, 0};
        tbl[3] = '{100, -100, 0, 0, 127, 1};
        tbl[4] = '{0, 0, 7, 2, 28, 0};

        bus.i_clk_enable = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_step_valid = 1'b0;
        bus.i_ready      = 1'b0;
        bus.i_delta_flat = '0;

        tick;
        tick;
        rst = 1'b0;
        check("rst_valid", bus.o_valid, 0);
        check("rst_class", bus.o_class, 0);
        check("rst_max", maxv(), 0);
        check("rst_count", bus.o_step_count, 0);
        check("rst_sat", bus.o_saturated, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_step_ready", bus.o_step_ready, 0);

        for (int i = 0; i < 5; i++) begin
            fill_rows(tbl[i].d0, tbl[i].d1, tbl[i].d2);
            run_steps(1'b0);
            finish_run($sformatf("tbl%0d", i), tbl[i].cls, tbl[i].mx, tbl[i].sat);
        end

        fill_rows(100, -100, 0);
        bus.i_start = 1'b1;
        tick;
        bus.i_start = 1'b0;
        send_step(0);
        check("sat_step1", bus.o_saturated, 0);
        send_step(1);
        check("sat_step2", bus.o_saturated, 1);
        send_step(2);
        send_step(3);
        finish_run("sat_seq", 0, 127, 1);

        fill_rows(1, 5, 2);
        run_steps(1'b0);
        while (!bus.o_valid) tick;
        bus.i_step_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            check("bp_valid", bus.o_valid, 1);
            check("bp_class", bus.o_class, 1);
            check("bp_max", maxv(), 20);
            check("bp_step_ready", bus.o_step_ready, 0);
            check("bp_count", bus.o_step_count, NS);
        end
        bus.i_step_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        tick;
        bus.i_ready = 1'b0;
        bus.i_start = 1'b0;
        check("b2b_valid", bus.o_valid, 0);
        check("b2b_count", bus.o_step_count, 0);
        check("b2b_accum", bus.o_step_ready, 1);

        fill_rows(9, 9, 9);
        send_step(0);
        send_step(1);
        check("abort_pre_count", bus.o_step_count, 2);
        bus.i_abort = 1'b1;
        bus.i_step_valid = 1'b1;
        tick;
        bus.i_abort = 1'b0;
        bus.i_step_valid = 1'b0;
        check("abort_busy", bus.o_busy, 0);
        check("abort_step_ready", bus.o_step_ready, 0);
        check("abort_count", bus.o_step_count, 2);
        cls = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (bus.o_valid) cls++;
        end
        check("abort_no_valid", cls, 0);
        check("abort_class_kept", bus.o_class, 1);
        check("abort_max_kept", maxv(), 20);
        fill_rows(0, 0, 7);
        run_steps(1'b0);
        finish_run("fresh", 2, 28, 0);

        fill_rows(2, -3, 1);
        run_steps(1'b0);
        tick;
        bus.i_clk_enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            check("en_hold_valid", bus.o_valid, 0);
        end
        bus.i_clk_enable = 1'b1;
        tick;
        check("en_valid", bus.o_valid, 1);
        check("en_class", bus.o_class, 0);
        check("en_max", maxv(), 8);
        rst = 1'b1;
        bus.i_clk_enable = 1'b0;
        tick;
        rst = 1'b0;
        bus.i_clk_enable = 1'b1;
        check("rst2_valid", bus.o_valid, 0);
        check("rst2_class", bus.o_class, 0);
        check("rst2_max", maxv(), 0);
        check("rst2_count", bus.o_step_count, 0);
        check("rst2_sat", bus.o_saturated, 0);
        check("rst2_busy", bus.o_busy, 0);

        for (int r = 0; r < 12; r++) begin
            for (int s = 0; s < NS; s++) begin
                for (int k = 0; k < VL; k++) begin
                    m_d[s][k] = int'($urandom_range(0, 2 * HI + 1)) + LO;
                end
            end
            model(cls, mx, sat);
            run_steps(1'b1);
            finish_run($sformatf("rand%0d", r), cls, mx, sat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
